// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : alu_writeback
//  Brief    : ALU result capture, Z/N/C/V flag update and 2-entry writeback
//             buffer drained by the register file over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module alu_writeback #(
   parameter int OPTION_REG_WIDTH     = 64,
   parameter int OPTION_RF_ADDR_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [3:0]                      in_opcode,
   input  logic [OPTION_REG_WIDTH-1:0]     in_result,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] in_dest,
   input  logic                            in_carry,
   input  logic                            in_overflow,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic [OPTION_REG_WIDTH-1:0]     wb_data,
   output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_addr,
   output logic                            flag_z,
   output logic                            flag_n,
   output logic                            flag_c,
   output logic                            flag_v,
   output logic [1:0]                      fill
);

   localparam logic [3:0] c_OP_CMP = 4'd0;
   localparam logic [3:0] c_OP_ADD = 4'd1;
   localparam logic [3:0] c_OP_SUB = 4'd2;

   logic [1:0]                      r_fill;
   logic [OPTION_REG_WIDTH-1:0]     r_head_data;
   logic [OPTION_RF_ADDR_WIDTH-1:0] r_head_addr;
   logic [OPTION_REG_WIDTH-1:0]     r_tail_data;
   logic [OPTION_RF_ADDR_WIDTH-1:0] r_tail_addr;
   logic                            r_z;
   logic                            r_n;
   logic                            r_c;
   logic                            r_v;

   logic w_accept;
   logic w_enq;
   logic w_deq;
   logic w_flag_op;

   // Handshake outputs come from registered occupancy only.
   assign in_ready  = (r_fill != 2'd2);
   assign wb_valid  = (r_fill != 2'd0);
   assign w_accept  = in_valid & in_ready;
   assign w_enq     = w_accept & (in_opcode != c_OP_CMP);
   assign w_deq     = wb_valid & wb_ready;
   assign w_flag_op = (in_opcode == c_OP_CMP) | (in_opcode == c_OP_ADD) |
                      (in_opcode == c_OP_SUB);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fill      <= 2'd0;
         r_head_data <= '0;
         r_head_addr <= '0;
         r_tail_data <= '0;
         r_tail_addr <= '0;
      end else if (flush) begin
         r_fill <= 2'd0;
      end else begin
         case (r_fill)
            2'd0: begin
               if (w_enq) begin
                  r_head_data <= in_result;
                  r_head_addr <= in_dest;
                  r_fill      <= 2'd1;
               end
            end
            2'd1: begin
               // Simultaneous enqueue/dequeue replaces the head in place.
               if (w_enq && w_deq) begin
                  r_head_data <= in_result;
                  r_head_addr <= in_dest;
               end else if (w_enq) begin
                  r_tail_data <= in_result;
                  r_tail_addr <= in_dest;
                  r_fill      <= 2'd2;
               end else if (w_deq) begin
                  r_fill <= 2'd0;
               end
            end
            2'd2: begin
               if (w_deq) begin
                  r_head_data <= r_tail_data;
                  r_head_addr <= r_tail_addr;
                  r_fill      <= 2'd1;
               end
            end
            default: r_fill <= 2'd0;
         endcase
      end
   end

   // Flags ignore flush so a flag op accepted alongside a kill still lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_z <= 1'b0;
         r_n <= 1'b0;
         r_c <= 1'b0;
         r_v <= 1'b0;
      end else if (w_accept && w_flag_op) begin
         r_z <= (in_result == '0);
         r_n <= in_result[OPTION_REG_WIDTH-1];
         r_c <= in_carry;
         r_v <= in_overflow;
      end
   end

   assign wb_data = r_head_data;
   assign wb_addr = r_head_addr;
   assign flag_z  = r_z;
   assign flag_n  = r_n;
   assign flag_c  = r_c;
   assign flag_v  = r_v;
   assign fill    = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_writeback
//  Brief    : Directed and random checks of alu_writeback against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_writeback;

   localparam int W = 64;
   localparam int A = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_opcode;
   logic [W-1:0] in_result;
   logic [A-1:0] in_dest;
   logic         in_carry;
   logic         in_overflow;
   logic         wb_valid;
   logic         wb_ready;
   logic [W-1:0] wb_data;
   logic [A-1:0] wb_addr;
   logic         flag_z;
   logic         flag_n;
   logic         flag_c;
   logic         flag_v;
   logic [1:0]   fill;

   alu_writeback #(
      .OPTION_REG_WIDTH     (W),
      .OPTION_RF_ADDR_WIDTH (A)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_result   (in_result),
      .in_dest     (in_dest),
      .in_carry    (in_carry),
      .in_overflow (in_overflow),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_data     (wb_data),
      .wb_addr     (wb_addr),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_c      (flag_c),
      .flag_v      (flag_v),
      .fill        (fill)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [A-1:0] addr;
      logic [W-1:0] data;
   } ent_t;

   ent_t       q[$];
   logic [3:0] mflags;   // {Z,N,C,V}
   int         n_cmp = 0;
   int         n_err = 0;

   localparam logic [3:0] OP_CMP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
      chk("fill",     64'(fill),     64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("flags",    64'({flag_z, flag_n, flag_c, flag_v}), 64'(mflags));
      if (q.size() != 0) begin
         chk("wb_data", 64'(wb_data), 64'(q[0].data));
         chk("wb_addr", 64'(wb_addr), 64'(q[0].addr));
      end
   endtask

   // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
   task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] res,
                       input logic [A-1:0] d, input logic c, input logic o,
                       input logic wr, input logic fl);
      bit   acc;
      bit   deq;
      ent_t e;
      in_valid    = v;
      in_opcode   = op;
      in_result   = res;
      in_dest     = d;
      in_carry    = c;
      in_overflow = o;
      wb_ready    = wr;
      flush       = fl;
      @(posedge clk);
      acc = v && (q.size() < 2);
      deq = (q.size() > 0) && wr;
      if (acc && (op == OP_CMP || op == OP_ADD || op == OP_SUB))
         mflags = {res == '0, res[W-1], c, o};
      if (fl) begin
         q.delete();
      end else begin
         if (deq) void'(q.pop_front());
         if (acc && op != OP_CMP) begin
            e.addr = d;
            e.data = res;
            q.push_back(e);
         end
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input logic wr);
      step(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, wr, 1'b0);
   endtask

   initial begin
      logic [W-1:0] r;
      rst = 1'b0;
      flush = 1'b0; in_valid = 1'b0; in_opcode = '0; in_result = '0;
      in_dest = '0; in_carry = 1'b0; in_overflow = 1'b0; wb_ready = 1'b0;
      q.delete();
      mflags = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_fill",     64'(fill),     64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_flags",    64'({flag_z, flag_n, flag_c, flag_v}), 64'h0);
      check_model();

      // Single ADD of zero with carry
      step(1'b1, OP_ADD, '0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("add_wb_valid", 64'(wb_valid), 64'd1);
      chk("add_wb_addr",  64'(wb_addr),  64'd3);
      chk("add_wb_data",  64'(wb_data),  64'd0);
      chk("add_flags",    64'({flag_z, flag_n, flag_c, flag_v}), 64'b1010);
      idle(1'b1);
      chk("add_drained", 64'(wb_valid), 64'd0);

      // Back-pressure, third result held off, in-order drain
      step(1'b1, OP_ADD, 64'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, OP_SUB, 64'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_fill",     64'(fill),     64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step(1'b1, OP_ADD, 64'h33, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_held_fill", 64'(fill),    64'd2);
      chk("bp_head0",     64'(wb_data), 64'h11);
      idle(1'b1);
      chk("bp_head1",     64'(wb_data), 64'h22);
      idle(1'b1);
      chk("bp_empty",     64'(wb_valid), 64'd0);

      // CMP updates flags but never enqueues
      step(1'b1, OP_ADD, 64'h44, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, OP_CMP, 64'h8000_0000_0000_0000, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("cmp_fill",  64'(fill),    64'd1);
      chk("cmp_head",  64'(wb_addr), 64'd5);
      chk("cmp_flags", 64'({flag_z, flag_n, flag_c, flag_v}), 64'b0101);

      // fill=1 with simultaneous accept and dequeue
      step(1'b1, OP_ADD, 64'h55, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("swap_fill", 64'(fill),    64'd1);
      chk("swap_data", 64'(wb_data), 64'h55);
      chk("swap_addr", 64'(wb_addr), 64'd6);

      // Flush when full: SUB is not accepted since in_ready=0
      step(1'b1, OP_ADD, 64'h66, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, OP_SUB, 64'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("flush_full_fill",  64'(fill),     64'd0);
      chk("flush_full_valid", 64'(wb_valid), 64'd0);
      // Flush at fill=1 with an accepted SUB: flags still take the SUB
      step(1'b1, OP_ADD, '0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_flush_z", 64'(flag_z), 64'd1);
      step(1'b1, OP_SUB, 64'd5, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("flush_fill",  64'(fill),     64'd0);
      chk("flush_valid", 64'(wb_valid), 64'd0);
      chk("flush_flags", 64'({flag_z, flag_n, flag_c, flag_v}), 64'b0010);

      // Random traffic against the queue model
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
         step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 5)), r,
              5'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 39) == 0);
      end

      // Asynchronous reset mid-stream
      step(1'b1, OP_SUB, 64'hFFFF_0000_0000_0001, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, OP_ADD, 64'h77, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_fill", 64'(fill), 64'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_fill",     64'(fill),     64'd0);
      chk("arst_wb_valid", 64'(wb_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_wb_data",  64'(wb_data),  64'd0);
      chk("arst_wb_addr",  64'(wb_addr),  64'd0);
      chk("arst_flags",    64'({flag_z, flag_n, flag_c, flag_v}), 64'h0);
      q.delete();
      mflags = 4'b0000;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
